// File: rtl/rtl_settings_pkg.sv
//------------------------------------------------------------------------------
// rtl_settings_pkg : shared types and helper functions for read_data_checker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rtl_settings_pkg;

  localparam int AMM_DATA_W = 128;
  localparam int AMM_BYTES  = AMM_DATA_W / 8;
  localparam int ADDR_W     = 32;
  localparam int ADDR_B_W   = $clog2(AMM_BYTES);
  localparam int WCNT_W     = 8;

  typedef enum logic [0:0] {
    FIX_DATA = 1'b0,
    RND_DATA = 1'b1
  } data_mode_t;

  // Everything the checker keeps once a descriptor is queued
  typedef struct packed {
    data_mode_t          data_mode;
    logic [7:0]          data_ptrn;
    logic [ADDR_W-1:0]   start_addr;
    logic [WCNT_W-1:0]   words_count;
    logic [ADDR_B_W-1:0] start_off;
    logic [ADDR_B_W-1:0] end_off;
  } cmp_desc_t;

  typedef struct packed {
    logic      trans_type;  // 1 = read, 0 = write
    cmp_desc_t desc;
  } cmp_struct_t;

  function automatic logic [AMM_BYTES-1:0] byteenable_ptrn(
    input logic                first,
    input logic                last,
    input logic [ADDR_B_W-1:0] start_off,
    input logic [ADDR_B_W-1:0] end_off
  );
    logic [AMM_BYTES-1:0] m;
    for (int i = 0; i < AMM_BYTES; i++) begin
      m[i] = (!first || (ADDR_B_W'(i) >= start_off)) &&
             (!last  || (ADDR_B_W'(i) <= end_off));
    end
    return m;
  endfunction

  function automatic logic [AMM_BYTES-1:0] check_vector(
    input logic [AMM_DATA_W-1:0] data,
    input logic [7:0]            exp_byte,
    input logic [AMM_BYTES-1:0]  ptrn
  );
    logic [AMM_BYTES-1:0] v;
    for (int i = 0; i < AMM_BYTES; i++) begin
      v[i] = ptrn[i] && (data[i*8 +: 8] != exp_byte);
    end
    return v;
  endfunction

  function automatic logic [ADDR_B_W-1:0] err_byte(input logic [AMM_BYTES-1:0] vec);
    logic [ADDR_B_W-1:0] idx;
    idx = '0;
    for (int i = AMM_BYTES - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_B_W'(i);
    end
    return idx;
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // An all-zero state would lock the LFSR
  function automatic logic [7:0] lfsr_seed(input logic [7:0] ptrn);
    return (ptrn == 8'h00) ? 8'h01 : ptrn;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_desc_fifo.sv
//------------------------------------------------------------------------------
// cmp_desc_fifo : show-ahead descriptor FIFO with registered full/empty
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cmp_desc_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // A pop in the same cycle makes room for a push even when full
  assign w_pop  = pop_i && !r_empty;
  assign w_push = push_i && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = r_mem[r_rptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule

`default_nettype wire

// File: rtl/read_data_checker.sv
//------------------------------------------------------------------------------
// read_data_checker : compares Avalon-MM read bursts against queued descriptors
// Optional: define CHECKER_ERR_CNT_EN to enable the failing-beat counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module read_data_checker
  import rtl_settings_pkg::*;
#(
  parameter int CMP_FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [$bits(cmp_struct_t)-1:0] cmp_struct_i,
  input  logic                          cmp_valid_i,
  output logic                          cmp_ready_o,
  input  logic [AMM_DATA_W-1:0]         readdata_i,
  input  logic                          readdatavalid_i,
  output logic                          err_o,
  output logic [ADDR_W-1:0]             err_addr_o,
  output logic [ADDR_B_W-1:0]           err_byte_o,
  output logic [7:0]                    err_data_o,
  output logic                          orphan_o,
  output logic                          busy_o,
  output logic [31:0]                   err_cnt_o
);

  localparam int DESC_W = $bits(cmp_desc_t);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  cmp_struct_t          w_cmp;
  cmp_desc_t            w_head;
  logic [DESC_W-1:0]    w_head_bits;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_first;
  logic                 w_last;
  logic                 w_orphan_hit;

  state_t               r_state;
  cmp_desc_t            r_cur;
  logic [WCNT_W-1:0]    r_beat_cnt;
  logic [7:0]           r_lfsr;

  logic                 r_s1_valid;
  logic [AMM_DATA_W-1:0] r_s1_data;
  logic [7:0]           r_s1_exp;
  logic [AMM_BYTES-1:0] r_s1_ptrn;
  logic [ADDR_W-1:0]    r_s1_addr;

  logic [AMM_BYTES-1:0] w_vec;
  logic                 w_fail;
  logic [ADDR_B_W-1:0]  w_fail_lane;

  logic                 r_err;
  logic [ADDR_W-1:0]    r_err_addr;
  logic [ADDR_B_W-1:0]  r_err_byte;
  logic [7:0]           r_err_data;
  logic                 r_orphan;

  assign w_cmp       = cmp_struct_t'(cmp_struct_i);
  assign w_head      = cmp_desc_t'(w_head_bits);
  assign cmp_ready_o = !w_fifo_full;

  // Write descriptors are accepted but never queued
  assign w_push = cmp_valid_i && cmp_ready_o && w_cmp.trans_type;

  assign w_first = (r_beat_cnt == '0);
  assign w_last  = (r_beat_cnt == r_cur.words_count);

  assign w_pop = !w_fifo_empty &&
                 ((r_state == IDLE) ||
                  ((r_state == CHECK) && readdatavalid_i && w_last));

  assign w_orphan_hit = (r_state == IDLE) && w_fifo_empty && readdatavalid_i;

  cmp_desc_fifo #(
    .DEPTH (CMP_FIFO_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_cmp.desc),
    .pop_i   (w_pop),
    .data_o  (w_head_bits),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Burst sequencer plus pipeline stage 1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_beat_cnt <= '0;
      r_lfsr     <= 8'h01;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_exp   <= '0;
      r_s1_ptrn  <= '0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cur      <= w_head;
            r_beat_cnt <= '0;
            r_lfsr     <= lfsr_seed(w_head.data_ptrn);
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          if (readdatavalid_i) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= readdata_i;
            r_s1_exp   <= (r_cur.data_mode == RND_DATA) ? r_lfsr : r_cur.data_ptrn;
            r_s1_ptrn  <= byteenable_ptrn(w_first, w_last, r_cur.start_off, r_cur.end_off);
            r_s1_addr  <= r_cur.start_addr + ADDR_W'(r_beat_cnt);
            if (w_last) begin
              if (w_pop) begin
                r_cur      <= w_head;
                r_beat_cnt <= '0;
                r_lfsr     <= lfsr_seed(w_head.data_ptrn);
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
              r_lfsr     <= lfsr_step(r_lfsr);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage 2: compare and capture the first failure only
  assign w_vec       = check_vector(r_s1_data, r_s1_exp, r_s1_ptrn);
  assign w_fail      = r_s1_valid && (|w_vec);
  assign w_fail_lane = err_byte(w_vec);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_err_byte <= '0;
      r_err_data <= '0;
      r_orphan   <= 1'b0;
    end else if (clear_i) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_err_byte <= '0;
      r_err_data <= '0;
      r_orphan   <= 1'b0;
    end else begin
      if (w_orphan_hit) r_orphan <= 1'b1;
      if (w_fail && !r_err) begin
        r_err      <= 1'b1;
        r_err_addr <= r_s1_addr;
        r_err_byte <= w_fail_lane;
        r_err_data <= r_s1_data[{w_fail_lane, 3'b000} +: 8];
      end
    end
  end

`ifdef CHECKER_ERR_CNT_EN
  logic [31:0] r_err_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_err_cnt <= '0;
    else if (clear_i)
      r_err_cnt <= '0;
    else if (w_fail && (r_err_cnt != 32'hFFFF_FFFF))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;
  assign err_byte_o = r_err_byte;
  assign err_data_o = r_err_data;
  assign orphan_o   = r_orphan;
  assign busy_o     = !w_fifo_empty || (r_state == CHECK) || r_s1_valid;

endmodule

`default_nettype wire

// File: tb/tb_read_data_checker.sv
//------------------------------------------------------------------------------
// tb_read_data_checker : directed self-checking bench for read_data_checker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_read_data_checker;
  import rtl_settings_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  clear;
  cmp_struct_t           cmp_struct;
  logic                  cmp_valid;
  logic                  cmp_ready;
  logic [AMM_DATA_W-1:0] readdata;
  logic                  rdv;
  logic                  err;
  logic [ADDR_W-1:0]     err_addr;
  logic [ADDR_B_W-1:0]   err_byte_s;
  logic [7:0]            err_data;
  logic                  orphan;
  logic                  busy;
  logic [31:0]           err_cnt;

  int n_cmp;
  int n_bad;

  read_data_checker #(.CMP_FIFO_DEPTH(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .cmp_struct_i    (cmp_struct),
    .cmp_valid_i     (cmp_valid),
    .cmp_ready_o     (cmp_ready),
    .readdata_i      (readdata),
    .readdatavalid_i (rdv),
    .err_o           (err),
    .err_addr_o      (err_addr),
    .err_byte_o      (err_byte_s),
    .err_data_o      (err_data),
    .orphan_o        (orphan),
    .busy_o          (busy),
    .err_cnt_o       (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cmp_struct_t mk(input logic rd, input data_mode_t m, input logic [7:0] p,
                                     input logic [31:0] a, input logic [7:0] wc,
                                     input logic [3:0] so, input logic [3:0] eo);
    cmp_struct_t d;
    d.trans_type       = rd;
    d.desc.data_mode   = m;
    d.desc.data_ptrn   = p;
    d.desc.start_addr  = a;
    d.desc.words_count = wc;
    d.desc.start_off   = so;
    d.desc.end_off     = eo;
    return d;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic push(input cmp_struct_t d);
    cmp_struct = d;
    cmp_valid  = 1'b1;
    tick();
    cmp_valid  = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d);
    readdata = d;
    rdv      = 1'b1;
    tick();
    rdv      = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; clear = 1'b0; cmp_valid = 1'b0; rdv = 1'b0;
    readdata = '0; cmp_struct = '0;
    tick(); tick();

    chk("rst_err", err, 0);
    chk("rst_ready", cmp_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_orphan", orphan, 0);
    chk("rst_addr", err_addr, 0);
    chk("rst_errcnt", err_cnt, 0);
    rst = 1'b0;
    tick();

    // write descriptors are dropped
    push(mk(1'b0, FIX_DATA, 8'hA5, 32'h0, 8'd0, 4'd0, 4'd15));
    chk("wr_drop_busy", busy, 0);

    // clean 4-beat FIX burst
    push(mk(1'b1, FIX_DATA, 8'hA5, 32'h40, 8'd3, 4'd0, 4'd15));
    tick();
    for (int i = 0; i < 4; i++) beat(fill(8'hA5));
    chk("fix_busy_1", busy, 1);
    tick();
    chk("fix_busy_0", busy, 0);
    chk("fix_err", err, 0);

    // beat 2 lane 5 corrupt, then beat 3 lane 0 corrupt (must not overwrite)
    push(mk(1'b1, FIX_DATA, 8'hA5, 32'h100, 8'd3, 4'd0, 4'd15));
    tick();
    beat(fill(8'hA5));
    beat(fill(8'hA5));
    d = fill(8'hA5); d[47:40] = 8'h00;
    beat(d);
    chk("e1_early", err, 0);
    d = fill(8'hA5); d[7:0] = 8'h33;
    beat(d);
    chk("e1_err", err, 1);
    chk("e1_addr", err_addr, 32'h102);
    chk("e1_byte", err_byte_s, 5);
    chk("e1_data", err_data, 8'h00);
    tick();
    chk("e1_keep_addr", err_addr, 32'h102);
    chk("e1_keep_byte", err_byte_s, 5);
`ifdef CHECKER_ERR_CNT_EN
    chk("e1_cnt", err_cnt, 2);
`else
    chk("e1_cnt", err_cnt, 0);
`endif
    do_clear();
    chk("clr_err", err, 0);
    chk("clr_addr", err_addr, 0);
    chk("clr_byte", err_byte_s, 0);

    // single beat, only lanes 4..6 checked
    push(mk(1'b1, FIX_DATA, 8'hA5, 32'h200, 8'd0, 4'd4, 4'd6));
    tick();
    d = fill(8'h00); d[55:32] = {3{8'hA5}};
    beat(d);
    tick();
    chk("sb_ok", err, 0);
    push(mk(1'b1, FIX_DATA, 8'hA5, 32'h200, 8'd0, 4'd4, 4'd6));
    tick();
    d = fill(8'h00); d[47:32] = {2{8'hA5}}; d[55:48] = 8'h11;
    beat(d);
    tick();
    chk("sb_err", err, 1);
    chk("sb_byte", err_byte_s, 6);
    chk("sb_addr", err_addr, 32'h200);
    chk("sb_data", err_data, 8'h11);
    do_clear();

    // RND: seed C0 -> C0, 81, 03
    push(mk(1'b1, RND_DATA, 8'hC0, 32'h300, 8'd2, 4'd0, 4'd15));
    tick();
    beat(fill(8'hC0));
    beat(fill(8'h81));
    beat(fill(8'h03));
    tick();
    chk("rnd_ok", err, 0);

    // RND: seed 0 -> 01, 02; beat 1 lane 3 corrupt
    push(mk(1'b1, RND_DATA, 8'h00, 32'h310, 8'd1, 4'd0, 4'd15));
    tick();
    beat(fill(8'h01));
    d = fill(8'h02); d[31:24] = 8'hFF;
    beat(d);
    chk("rnd_b0", err, 0);
    tick();
    chk("rnd_err", err, 1);
    chk("rnd_addr", err_addr, 32'h311);
    chk("rnd_byte", err_byte_s, 3);
    chk("rnd_data", err_data, 8'hFF);

    // orphan beat
    beat(fill(8'h55));
    chk("orph_set", orphan, 1);
    do_clear();
    chk("orph_clr", orphan, 0);
    chk("orph_clr_err", err, 0);

    // fill FIFO: first descriptor goes straight to the FSM, 8 more fill it
    for (int k = 0; k < 9; k++) begin
      cmp_struct = mk(1'b1, FIX_DATA, 8'h10 + 8'(k), 32'h400 + 32'(k * 16), 8'd0, 4'd0, 4'd15);
      cmp_valid  = 1'b1;
      tick();
    end
    cmp_valid = 1'b0;
    chk("full_ready", cmp_ready, 0);
    push(mk(1'b1, FIX_DATA, 8'hEE, 32'h900, 8'd0, 4'd0, 4'd15));
    chk("full_still", cmp_ready, 0);
    beat(fill(8'h10));
    chk("pop_ready", cmp_ready, 1);
    for (int k = 1; k < 9; k++) begin
      d = fill(8'h10 + 8'(k));
      if (k == 5) d[79:72] = 8'hEE;
      beat(d);
    end
    tick();
    chk("b2b_busy", busy, 0);
    chk("b2b_err", err, 1);
    chk("b2b_addr", err_addr, 32'h450);
    chk("b2b_byte", err_byte_s, 9);
    chk("b2b_data", err_data, 8'hEE);
    chk("b2b_orph", orphan, 0);
`ifdef CHECKER_ERR_CNT_EN
    chk("b2b_cnt", err_cnt, 1);
`else
    chk("b2b_cnt", err_cnt, 0);
`endif

    // reset mid-burst discards it
    push(mk(1'b1, FIX_DATA, 8'hA5, 32'h500, 8'd3, 4'd0, 4'd15));
    tick();
    beat(fill(8'hA5));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_err", err, 0);
    chk("mr_ready", cmp_ready, 1);
    beat(fill(8'hA5));
    chk("mr_orph", orphan, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
